// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_pkg
// Purpose  : Shared definitions for the UART TX message arbiter: the arbiter
//            FSM state encodings and the byte width of the FIFO write port.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

   // Width of one byte lane on the requester side and on the FIFO port.
   localparam int c_byte_w = 8;

   // Registered arbiter state. The encodings are fixed so that a state
   // value seen on a debug bus always means the same thing.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEND   = 2'd1,
      ST_STROBE = 2'd2
   } arb_state_t;

endpackage : uart_tx_arbiter_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. It searches the request
//            vector upward from the entry after last_owner, wrapping at
//            NUM_REQ, and reports the first set bit. It holds no state, so
//            other dispatchers can reuse it with their own owner register.
// Ports    : req           - request vector
//            last_owner    - index of the previous winner
//            winner_onehot - one-hot winner (all zero when nothing requests)
//            winner_idx    - binary index of the winner
//            any_valid     - at least one request is set
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int NUM_REQ  = 4,
   parameter int REQ_BITS = 2
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [REQ_BITS-1:0] last_owner,
   output logic [NUM_REQ-1:0]  winner_onehot,
   output logic [REQ_BITS-1:0] winner_idx,
   output logic                any_valid
);

   logic [REQ_BITS-1:0] w_cand;

   // Candidate i is (last_owner + 1 + i) mod NUM_REQ. The first candidate
   // that requests wins; later hits are ignored through any_valid.
   always_comb begin
      winner_onehot = '0;
      winner_idx    = '0;
      any_valid     = 1'b0;
      w_cand        = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_cand = REQ_BITS'((int'(last_owner) + 1 + i) % NUM_REQ);
         if (!any_valid && req[w_cand]) begin
            any_valid             = 1'b1;
            winner_idx            = w_cand;
            winner_onehot[w_cand] = 1'b1;
         end
      end
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares the byte-wide, active-low-strobed TX write port of the
//            UART FIFO among NUM_REQ message sources. Grants are given
//            round-robin and held for a whole message, so bytes from
//            different sources never interleave. A grant is forcibly
//            released after MAX_BURST bytes to stop one source hogging the
//            port. All outputs are registered.
// Ports    : clk       - system clock, rising edge
//            nreset    - synchronous active-low reset
//            req       - per-requester message pending
//            last      - per-requester: presented byte ends the message
//            data      - flattened bytes, requester i on [i*8+7:i*8]
//            ack       - one-cycle pulse: presented byte was taken
//            grant     - one-hot current owner, zero when idle
//            fifo_full - TX FIFO full
//            fifo_data - byte to the FIFO
//            fifo_nwr  - active-low FIFO write strobe
// Revision : 1.0 - initial release
// ============================================================================
import uart_tx_arbiter_pkg::*;

module uart_tx_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int REQ_BITS   = 2,
   parameter int MAX_BURST  = 64,
   parameter int BURST_BITS = 7
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    last,
   input  logic [NUM_REQ*8-1:0]  data,
   output logic [NUM_REQ-1:0]    ack,
   output logic [NUM_REQ-1:0]    grant,
   input  logic                  fifo_full,
   output logic [c_byte_w-1:0]   fifo_data,
   output logic                  fifo_nwr
);

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   arb_state_t            r_state;
   arb_state_t            w_state_nxt;
   logic [NUM_REQ-1:0]    r_grant;
   logic [NUM_REQ-1:0]    w_grant_nxt;
   logic [NUM_REQ-1:0]    r_ack;
   logic [NUM_REQ-1:0]    w_ack_nxt;
   logic [REQ_BITS-1:0]   r_owner;
   logic [REQ_BITS-1:0]   w_owner_nxt;
   logic [REQ_BITS-1:0]   r_last_owner;
   logic [REQ_BITS-1:0]   w_last_owner_nxt;
   logic [BURST_BITS-1:0] r_burst;
   logic [BURST_BITS-1:0] w_burst_nxt;
   logic                  r_last_flag;
   logic                  w_last_flag_nxt;
   logic                  r_fifo_nwr;
   logic                  w_fifo_nwr_nxt;
   logic [c_byte_w-1:0]   r_fifo_data;
   logic [c_byte_w-1:0]   w_fifo_data_nxt;

   // ------------------------------------------------------------------------
   // Requester byte lanes
   // ------------------------------------------------------------------------
   logic [c_byte_w-1:0]   w_data_arr [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_data_arr[gi] = data[gi*c_byte_w +: c_byte_w];
   end

   // ------------------------------------------------------------------------
   // Round-robin selection
   // ------------------------------------------------------------------------
   logic [NUM_REQ-1:0]    w_pick_onehot;
   logic [REQ_BITS-1:0]   w_pick_idx;
   logic                  w_pick_valid;

   rr_pick #(
      .NUM_REQ  (NUM_REQ),
      .REQ_BITS (REQ_BITS)
   ) u_rr_pick (
      .req           (req),
      .last_owner    (r_last_owner),
      .winner_onehot (w_pick_onehot),
      .winner_idx    (w_pick_idx),
      .any_valid     (w_pick_valid)
   );

   // ------------------------------------------------------------------------
   // Register process
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_ack        <= '0;
         r_owner      <= '0;
         // Pointing at the highest index makes requester 0 win first.
         r_last_owner <= REQ_BITS'(NUM_REQ - 1);
         r_burst      <= '0;
         r_last_flag  <= 1'b0;
         r_fifo_nwr   <= 1'b1;
         r_fifo_data  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_grant      <= w_grant_nxt;
         r_ack        <= w_ack_nxt;
         r_owner      <= w_owner_nxt;
         r_last_owner <= w_last_owner_nxt;
         r_burst      <= w_burst_nxt;
         r_last_flag  <= w_last_flag_nxt;
         r_fifo_nwr   <= w_fifo_nwr_nxt;
         r_fifo_data  <= w_fifo_data_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------------
   // ack and the strobe are single-cycle pulses, so their defaults are the
   // inactive level; only the SEND-with-space branch asserts them. The
   // FIFO byte is held by default so it stays valid through the high cycle
   // after each strobe.
   always_comb begin
      w_state_nxt      = r_state;
      w_grant_nxt      = r_grant;
      w_ack_nxt        = '0;
      w_owner_nxt      = r_owner;
      w_last_owner_nxt = r_last_owner;
      w_burst_nxt      = r_burst;
      w_last_flag_nxt  = r_last_flag;
      w_fifo_nwr_nxt   = 1'b1;
      w_fifo_data_nxt  = r_fifo_data;

      case (r_state)
         ST_IDLE: begin
            w_grant_nxt = '0;
            if (w_pick_valid) begin
               w_grant_nxt = w_pick_onehot;
               w_owner_nxt = w_pick_idx;
               w_burst_nxt = '0;
               w_state_nxt = ST_SEND;
            end
         end

         ST_SEND: begin
            if (!req[r_owner]) begin
               // Requester withdrew mid-message: release without a strobe.
               w_grant_nxt      = '0;
               w_last_owner_nxt = r_owner;
               w_state_nxt      = ST_IDLE;
            end else if (!fifo_full) begin
               w_fifo_data_nxt  = w_data_arr[r_owner];
               w_fifo_nwr_nxt   = 1'b0;
               w_ack_nxt        = r_grant;
               w_last_flag_nxt  = last[r_owner];
               w_burst_nxt      = r_burst + BURST_BITS'(1);
               w_state_nxt      = ST_STROBE;
            end
         end

         ST_STROBE: begin
            // The forced release at MAX_BURST leaves req untouched, so the
            // requester simply re-enters arbitration behind the others.
            if (r_last_flag || (r_burst == BURST_BITS'(MAX_BURST))) begin
               w_grant_nxt      = '0;
               w_last_owner_nxt = r_owner;
               w_state_nxt      = ST_IDLE;
            end else begin
               w_state_nxt      = ST_SEND;
            end
         end

         default: begin
            w_grant_nxt = '0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign ack       = r_ack;
   assign grant     = r_grant;
   assign fifo_data = r_fifo_data;
   assign fifo_nwr  = r_fifo_nwr;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=4).
//            A cycle-exact vector table covers single-requester transfer
//            timing and FIFO back-pressure; queue-driven requesters cover
//            ordering, contiguity, forced release, reset and withdrawal.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int NUM = 4;

   logic        clk = 1'b0;
   logic        nreset;
   logic [3:0]  req;
   logic [3:0]  last;
   logic [31:0] data;
   logic        fifo_full;
   logic [3:0]  ack;
   logic [3:0]  grant;
   logic [7:0]  fifo_data;
   logic        fifo_nwr;

   int checks = 0;
   int errors = 0;

   uart_tx_arbiter #(
      .NUM_REQ    (4),
      .REQ_BITS   (2),
      .MAX_BURST  (4),
      .BURST_BITS (7)
   ) dut (
      .clk       (clk),
      .nreset    (nreset),
      .req       (req),
      .last      (last),
      .data      (data),
      .ack       (ack),
      .grant     (grant),
      .fifo_full (fifo_full),
      .fifo_data (fifo_data),
      .fifo_nwr  (fifo_nwr)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Vector table
   // ------------------------------------------------------------------------
   typedef struct {
      logic [3:0]  req;
      logic [3:0]  last;
      logic [31:0] data;
      logic        full;
      logic [3:0]  e_grant;
      logic [3:0]  e_ack;
      logic        e_nwr;
      logic [7:0]  e_fdata;
   } vec_t;

   vec_t tbl[$];

   task automatic add_vec(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d,
                          input logic f, input logic [3:0] eg, input logic [3:0] ea,
                          input logic en, input logic [7:0] ed);
      vec_t v;
      v.req = r; v.last = l; v.data = d; v.full = f;
      v.e_grant = eg; v.e_ack = ea; v.e_nwr = en; v.e_fdata = ed;
      tbl.push_back(v);
   endtask

   // ------------------------------------------------------------------------
   // Requester model and FIFO monitor
   // ------------------------------------------------------------------------
   typedef logic [8:0] qe_t;          // {last, byte}
   qe_t         q [NUM][$];
   logic [3:0]  rq_en   = 4'b0000;
   bit          model_en = 1'b0;

   logic [9:0]  cap[$];               // {owner, byte} per strobe
   logic [9:0]  exp_q[$];
   int          gap_viol = 0;
   int          ack_viol = 0;
   bit          prev_low = 1'b0;

   // Requesters advance at the falling edge after seeing ack.
   initial begin
      forever begin
         @(negedge clk);
         if (model_en) begin
            for (int i = 0; i < NUM; i++) begin
               if (ack[i] && q[i].size() > 0) void'(q[i].pop_front());
               if (rq_en[i] && q[i].size() > 0) begin
                  req[i]          = 1'b1;
                  last[i]         = q[i][0][8];
                  data[i*8 +: 8]  = q[i][0][7:0];
               end else begin
                  req[i]          = 1'b0;
                  last[i]         = 1'b0;
                  data[i*8 +: 8]  = 8'h00;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (nreset) begin
            if (!fifo_nwr) begin
               logic [1:0] own;
               own = 2'd0;
               for (int i = 0; i < NUM; i++) if (grant[i]) own = 2'(i);
               cap.push_back({own, fifo_data});
               if (prev_low) gap_viol++;
            end
            if (((ack & ~grant) != 4'b0000) || !$onehot0(grant)) ack_viol++;
         end
         prev_low = !fifo_nwr;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required finish earlier", $time);
      $fatal(1);
   end

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   task automatic check_cap(input string name);
      checks++;
      if (cap.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s count: got %0d bytes, expected %0d", name, cap.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
         checks++;
         if (cap[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s byte%0d: got owner %0d data %h, expected owner %0d data %h",
                     name, i, cap[i][9:8], cap[i][7:0], exp_q[i][9:8], exp_q[i][7:0]);
         end
      end
      cap.delete();
      exp_q.delete();
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit done;
      done = 1'b0;
      for (int n = 0; n < budget && !done; n++) begin
         @(posedge clk);
         #1;
         if (grant == 4'b0000 && q[0].size() == 0 && q[1].size() == 0 &&
             q[2].size() == 0 && q[3].size() == 0)
            done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s timeout: grant=%b still busy, expected idle within %0d cycles",
                  name, grant, budget);
      end
   endtask

   task automatic load_msg(input int r, input logic [7:0] first, input int n);
      for (int k = 0; k < n; k++)
         q[r].push_back({(k == n - 1), first + 8'(k)});
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      nreset    = 1'b0;
      req       = 4'b0000;
      last      = 4'b0000;
      data      = 32'h0;
      fifo_full = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (grant !== 4'b0000 || ack !== 4'b0000 || fifo_nwr !== 1'b1 || fifo_data !== 8'h00) begin
         errors++;
         $display("FAIL reset: grant=%b ack=%b nwr=%b data=%h, expected 0000 0000 1 00",
                  grant, ack, fifo_nwr, fifo_data);
      end
      nreset = 1'b1;

      // Single requester 0: 0x5A then 0xA5 (last).
      add_vec(4'b0001, 4'b0000, 32'h0000_005A, 1'b0, 4'b0001, 4'b0000, 1'b1, 8'h00);
      add_vec(4'b0001, 4'b0000, 32'h0000_005A, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'h5A);
      add_vec(4'b0001, 4'b0001, 32'h0000_00A5, 1'b0, 4'b0001, 4'b0000, 1'b1, 8'h5A);
      add_vec(4'b0001, 4'b0001, 32'h0000_00A5, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'hA5);
      add_vec(4'b0000, 4'b0000, 32'h0,         1'b0, 4'b0000, 4'b0000, 1'b1, 8'hA5);
      add_vec(4'b0000, 4'b0000, 32'h0,         1'b0, 4'b0000, 4'b0000, 1'b1, 8'hA5);
      // Requester 1, one byte 0x77, FIFO full for 10 granted cycles.
      add_vec(4'b0010, 4'b0010, 32'h0000_7700, 1'b1, 4'b0010, 4'b0000, 1'b1, 8'hA5);
      for (int k = 0; k < 10; k++)
         add_vec(4'b0010, 4'b0010, 32'h0000_7700, 1'b1, 4'b0010, 4'b0000, 1'b1, 8'hA5);
      add_vec(4'b0010, 4'b0010, 32'h0000_7700, 1'b0, 4'b0010, 4'b0010, 1'b0, 8'h77);
      add_vec(4'b0000, 4'b0000, 32'h0,         1'b0, 4'b0000, 4'b0000, 1'b1, 8'h77);
      add_vec(4'b0000, 4'b0000, 32'h0,         1'b0, 4'b0000, 4'b0000, 1'b1, 8'h77);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         req       = tbl[i].req;
         last      = tbl[i].last;
         data      = tbl[i].data;
         fifo_full = tbl[i].full;
         @(posedge clk);
         #1;
         checks++;
         if (grant !== tbl[i].e_grant || ack !== tbl[i].e_ack ||
             fifo_nwr !== tbl[i].e_nwr || fifo_data !== tbl[i].e_fdata) begin
            errors++;
            $display("FAIL vec%0d: grant=%b ack=%b nwr=%b data=%h, expected grant=%b ack=%b nwr=%b data=%h",
                     i, grant, ack, fifo_nwr, fifo_data,
                     tbl[i].e_grant, tbl[i].e_ack, tbl[i].e_nwr, tbl[i].e_fdata);
         end
      end
      cap.delete();

      // Hand sequences use the queue-driven requesters from here on.
      @(negedge clk);
      fifo_full = 1'b0;
      model_en  = 1'b1;

      // Reset during STROBE: requester 2 has a 3-byte message.
      load_msg(2, 8'h51, 3);
      rq_en = 4'b0100;
      begin
         bit seen;
         seen = 1'b0;
         for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (!fifo_nwr) seen = 1'b1;
         end
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL rst_strobe_wait: no strobe seen, expected one within 20 cycles");
         end
      end
      nreset = 1'b0;
      q[2].delete();
      rq_en = 4'b0000;
      @(posedge clk);
      #1;
      checks++;
      if (fifo_nwr !== 1'b1 || grant !== 4'b0000 || ack !== 4'b0000) begin
         errors++;
         $display("FAIL mid_reset: nwr=%b grant=%b ack=%b, expected 1 0000 0000",
                  fifo_nwr, grant, ack);
      end
      nreset = 1'b1;
      exp_q.push_back({2'd2, 8'h51});
      check_cap("rst_partial");

      // Four one-byte messages at once, two rounds; order restarts at 0.
      for (int r = 0; r < NUM; r++) load_msg(r, 8'h10 + 8'(r), 1);
      rq_en = 4'b1111;
      wait_idle("rr_round1", 60);
      for (int r = 0; r < NUM; r++) exp_q.push_back({2'(r), 8'h10 + 8'(r)});
      check_cap("rr_round1");
      for (int r = 0; r < NUM; r++) load_msg(r, 8'h20 + 8'(r), 1);
      wait_idle("rr_round2", 60);
      for (int r = 0; r < NUM; r++) exp_q.push_back({2'(r), 8'h20 + 8'(r)});
      check_cap("rr_round2");

      // Requester 1: 3-byte message, requester 2: 1 byte; no interleave.
      load_msg(1, 8'h31, 3);
      load_msg(2, 8'h41, 1);
      wait_idle("contig", 60);
      exp_q.push_back({2'd1, 8'h31});
      exp_q.push_back({2'd1, 8'h32});
      exp_q.push_back({2'd1, 8'h33});
      exp_q.push_back({2'd2, 8'h41});
      check_cap("contig");

      // Forced release after 4 bytes: requester 0 streams 6, requester 3 cuts in.
      rq_en = 4'b0001;
      load_msg(0, 8'h60, 6);
      repeat (2) @(posedge clk);
      load_msg(3, 8'h7F, 1);
      rq_en = 4'b1001;
      wait_idle("burst", 80);
      for (int k = 0; k < 4; k++) exp_q.push_back({2'd0, 8'h60 + 8'(k)});
      exp_q.push_back({2'd3, 8'h7F});
      exp_q.push_back({2'd0, 8'h64});
      exp_q.push_back({2'd0, 8'h65});
      check_cap("burst");

      // Requester 1 withdraws after its first byte of three.
      rq_en = 4'b0010;
      load_msg(1, 8'h91, 3);
      begin
         bit seen;
         seen = 1'b0;
         for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (!fifo_nwr) seen = 1'b1;
         end
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL drop_wait: no strobe seen, expected one within 20 cycles");
         end
      end
      rq_en = 4'b0000;
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (grant !== 4'b0000 || fifo_nwr !== 1'b1) begin
         errors++;
         $display("FAIL drop_release: grant=%b nwr=%b, expected 0000 1", grant, fifo_nwr);
      end
      q[1].delete();
      exp_q.push_back({2'd1, 8'h91});
      check_cap("drop");

      // Protocol invariants observed over the whole run.
      checks++;
      if (gap_viol != 0) begin
         errors++;
         $display("FAIL strobe_gap: %0d back-to-back strobes, expected 0", gap_viol);
      end
      checks++;
      if (ack_viol != 0) begin
         errors++;
         $display("FAIL ack_owner: %0d cycles with bad ack/grant, expected 0", ack_viol);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
